kbd_serial_receiver: RTL and testbench

Serial keyboard receiver for the GFX test system. It deserialises 8N1 UART bytes from the host line into an 8-entry receive FIFO. It then delivers them one at a time to the control FSM through the same IRQ/IACK/IEND interrupt handshake used by the system timer. It sits directly upstream of the top-level sequencer's key buffer, between the `IN_SERIAL_RX` pin and the frame-select logic.

---
 rtl/kbd_serial_receiver_if.sv | 20 ++
 rtl/kbd_serial_receiver.sv | 173 +++++++++++++++++
 tb/tb_kbd_serial_receiver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_serial_receiver_if.sv
// Interrupt-style handshake bundle between the keyboard receiver and its consumer.
// The receiver side drives the byte and status flags; the consumer drives IACK/IEND.
interface kbd_serial_receiver_if;
    logic [7:0] DATA;
    logic       IRQ;
    logic       IACK;
    logic       IEND;
    logic       OVERRUN;
    logic       FRAME_ERR;

    modport master (
        output DATA, IRQ, OVERRUN, FRAME_ERR,
        input  IACK, IEND
    );

    modport slave (
        input  DATA, IRQ, OVERRUN, FRAME_ERR,
        output IACK, IEND
    );
endinterface

// File: rtl/kbd_serial_receiver.sv
// 8N1 serial keyboard receiver: deserialises bytes into a small FIFO and hands them
// to the control FSM one at a time through the IRQ/IACK/IEND handshake.
module kbd_serial_receiver #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int FIFO_ADDR_BITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  IN_SERIAL_RX,
    kbd_serial_receiver_if.master bus
);
    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]          HALF_LOAD  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]          FULL_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]          CNT_ONE    = CNT_W'(1);
    localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE    = FIFO_ADDR_BITS'(1);
    localparam logic [FIFO_ADDR_BITS:0]   CNT1       = (FIFO_ADDR_BITS + 1)'(1);
    localparam logic [FIFO_ADDR_BITS:0]   FULL_COUNT = (FIFO_ADDR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rxStateT;
    typedef enum logic {H_IDLE, H_SERVICE} hsStateT;

    logic                      rxMeta, rxs;
    rxStateT                   rxState, rxNext;
    logic [CNT_W-1:0]          bitCnt, bitCntNext;
    logic [2:0]                bitIdx, bitIdxNext;
    logic [7:0]                shiftReg, shiftNext;
    logic                      pushReq, frameErrNext, frameErr;

    logic [7:0]                mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wrPtr, rdPtr;
    logic [FIFO_ADDR_BITS:0]   count, countNext;
    logic                      fifoFull, doPush, doPop, dropByte;

    hsStateT                   hsState, hsNext;
    logic                      clrOverrun, overrun, irq, irqNext;
    logic [7:0]                dataQ;

    // The line idles high, so the synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= IN_SERIAL_RX;
            rxs    <= rxMeta;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rxState  <= R_IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            frameErr <= 1'b0;
        end else begin
            rxState  <= rxNext;
            bitCnt   <= bitCntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
            frameErr <= frameErrNext;
        end
    end

    // Half-bit delay after the start edge puts every later sample at mid-bit.
    always_comb begin
        rxNext       = rxState;
        bitCntNext   = bitCnt - CNT_ONE;
        bitIdxNext   = bitIdx;
        shiftNext    = shiftReg;
        pushReq      = 1'b0;
        frameErrNext = 1'b0;
        unique case (rxState)
            R_IDLE: begin
                bitCntNext = HALF_LOAD;
                if (!rxs) rxNext = R_START;
            end
            R_START: begin
                if (bitCnt == '0) begin
                    if (!rxs) begin
                        rxNext     = R_DATA;
                        bitIdxNext = '0;
                        bitCntNext = FULL_LOAD;
                    end else begin
                        rxNext = R_IDLE;
                    end
                end
            end
            R_DATA: begin
                if (bitCnt == '0) begin
                    shiftNext  = {rxs, shiftReg[7:1]};
                    bitCntNext = FULL_LOAD;
                    if (bitIdx == 3'd7) rxNext = R_STOP;
                    else                bitIdxNext = bitIdx + 3'd1;
                end
            end
            R_STOP: begin
                if (bitCnt == '0) begin
                    rxNext       = R_IDLE;
                    pushReq      = rxs;
                    frameErrNext = !rxs;
                end
            end
            default: rxNext = R_IDLE;
        endcase
    end

    always_comb begin
        hsNext     = hsState;
        doPop      = 1'b0;
        clrOverrun = 1'b0;
        case (hsState)
            H_IDLE: begin
                if (bus.IACK && irq) begin
                    doPop  = 1'b1;
                    hsNext = H_SERVICE;
                end
            end
            H_SERVICE: begin
                if (bus.IEND) begin
                    hsNext     = H_IDLE;
                    clrOverrun = 1'b1;
                end
            end
            default: hsNext = H_IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    always_comb begin
        fifoFull  = (count == FULL_COUNT);
        doPush    = pushReq && (!fifoFull || doPop);
        dropByte  = pushReq && fifoFull && !doPop;
        countNext = count;
        if (doPush && !doPop)      countNext = count + CNT1;
        else if (!doPush && doPop) countNext = count - CNT1;
        irqNext = (hsNext == H_IDLE) && (countNext != '0);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hsState <= H_IDLE;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            irq     <= 1'b0;
            overrun <= 1'b0;
            dataQ   <= '0;
        end else begin
            hsState <= hsNext;
            count   <= countNext;
            irq     <= irqNext;
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
                dataQ <= mem[rdPtr];
            end
            if (dropByte)        overrun <= 1'b1;
            else if (clrOverrun) overrun <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (doPush) mem[wrPtr] <= shiftReg;
    end

    assign bus.DATA      = dataQ;
    assign bus.IRQ       = irq;
    assign bus.OVERRUN   = overrun;
    assign bus.FRAME_ERR = frameErr;
endmodule

// File: tb/tb_kbd_serial_receiver.sv
// Directed and randomised bench for kbd_serial_receiver; expected bytes and flags come
// from a queue model of the FIFO and the handshake rules.
module tb_kbd_serial_receiver;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic CLK;
    logic RESET_N;
    logic rx;

    kbd_serial_receiver_if bus ();

    kbd_serial_receiver #(
        .CLKS_PER_BIT  (CPB),
        .FIFO_ADDR_BITS(3)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IN_SERIAL_RX(rx),
        .bus         (bus)
    );

    logic [7:0] expQ [$];
    logic       expOverrun;
    logic [7:0] expData;
    int         testsRun;
    int         failCount;
    int         irqRise;
    int         frameErrSeen;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelRx(input logic [7:0] b);
        if (expQ.size() < DEPTH) expQ.push_back(b);
        else                     expOverrun = 1'b1;
    endtask

    // Drives one full frame starting at the current negedge; cycle 0 is the start bit.
    task automatic sendFrame(input logic [7:0] b, input logic goodStop,
                             input int iackAt, input int abortAt);
        int bitPos;
        irqRise      = -1;
        frameErrSeen = 0;
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge CLK);
            if (bus.FRAME_ERR === 1'b1) frameErrSeen++;
            if (bus.IRQ === 1'b1 && irqRise < 0) irqRise = c;
            bitPos   = c / CPB;
            rx       = (bitPos == 0) ? 1'b0 : (bitPos == 9) ? goodStop : b[bitPos-1];
            bus.IACK = (c == iackAt);
            if (c == abortAt) return;
        end
    endtask

    task automatic watch(input int n, output int irqHi, output int ferrHi);
        irqHi  = 0;
        ferrHi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (bus.IRQ !== 1'b0)      irqHi++;
            if (bus.FRAME_ERR !== 1'b0) ferrHi++;
        end
    endtask

    task automatic waitIrq(input int maxCycles);
        int n = 0;
        while (bus.IRQ !== 1'b1 && n < maxCycles) begin
            @(negedge CLK);
            n++;
        end
        check("irqWait", bus.IRQ, 1'b1);
    endtask

    task automatic endService();
        bus.IEND = 1'b1;
        @(negedge CLK);
        bus.IEND   = 1'b0;
        expOverrun = 1'b0;
        check("irqAfterIend", bus.IRQ, (expQ.size() != 0));
        check("overrunAfterIend", bus.OVERRUN, expOverrun);
    endtask

    task automatic serviceOne(input logic combined);
        waitIrq(400);
        bus.IACK = 1'b1;
        bus.IEND = combined;
        @(negedge CLK);
        bus.IACK = 1'b0;
        bus.IEND = 1'b0;
        expData  = expQ.pop_front();
        check("dataAfterIack", bus.DATA, expData);
        check("irqAfterIack", bus.IRQ, 1'b0);
        if (combined) begin
            repeat (2) @(negedge CLK);
            check("iendIgnoredWithIack", bus.IRQ, 1'b0);
        end
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        endService();
    endtask

    task automatic drain();
        while (expQ.size() != 0) serviceOne(1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "Data"}, bus.DATA, 8'h00);
        check({tag, "Irq"}, bus.IRQ, 1'b0);
        check({tag, "Overrun"}, bus.OVERRUN, 1'b0);
        check({tag, "FrameErr"}, bus.FRAME_ERR, 1'b0);
    endtask

    initial begin
        int         irqHi, ferrHi, n;
        logic [7:0] b, popped;

        testsRun   = 0;
        failCount  = 0;
        expOverrun = 1'b0;
        expData    = 8'h00;
        RESET_N    = 1'b0;
        rx         = 1'b1;
        bus.IACK   = 1'b0;
        bus.IEND   = 1'b0;
        repeat (3) @(negedge CLK);
        checkResetValues("reset");
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);

        // Single byte: IRQ latency from the start edge, then one full service.
        sendFrame(8'h31, 1'b1, -1, -1);
        modelRx(8'h31);
        check("irqRiseInWindow", (irqRise >= 154 && irqRise <= 156), 1'b1);
        serviceOne(1'b0);

        rx = 1'b0;
        repeat (3) @(negedge CLK);
        rx = 1'b1;
        watch(60, irqHi, ferrHi);
        check("glitchNoIrq", 16'(irqHi), 16'd0);
        check("glitchNoFrameErr", 16'(ferrHi), 16'd0);

        sendFrame(8'h32, 1'b0, -1, -1);
        rx = 1'b1;
        watch(60, irqHi, ferrHi);
        check("frameErrPulseCycles", 16'(frameErrSeen + ferrHi), 16'd1);
        check("frameErrNoPush", 16'(irqHi), 16'd0);

        // Four frames with no idle gap queue up; the first service uses IACK+IEND together.
        for (int i = 0; i < 4; i++) begin
            sendFrame(8'h31 + 8'(i), 1'b1, -1, -1);
            modelRx(8'h31 + 8'(i));
        end
        rx = 1'b1;
        check("queuedIrq", bus.IRQ, 1'b1);
        serviceOne(1'b1);
        drain();

        for (int i = 0; i < 9; i++) begin
            sendFrame(8'h40 + 8'(i), 1'b1, -1, -1);
            modelRx(8'h40 + 8'(i));
            check("overrunDuringFill", bus.OVERRUN, expOverrun);
        end
        rx = 1'b1;
        check("overrunSet", bus.OVERRUN, 1'b1);
        drain();

        // Fill to full, then land IACK on the exact cycle of the 0x55 stop-bit push.
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            sendFrame(b, 1'b1, -1, -1);
            modelRx(b);
        end
        check("fullNoOverrun", bus.OVERRUN, 1'b0);
        sendFrame(8'h55, 1'b1, 154, -1);
        rx     = 1'b1;
        popped = expQ.pop_front();
        expQ.push_back(8'h55);
        expData = popped;
        check("simulPopData", bus.DATA, popped);
        check("simulIrqLow", bus.IRQ, 1'b0);
        check("simulOverrun", bus.OVERRUN, 1'b0);
        endService();
        drain();
        check("lastDrainedIs55", expData, 8'h55);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(2, 11);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                sendFrame(b, 1'b1, -1, -1);
                modelRx(b);
            end
            rx = 1'b1;
            check("randOverrun", bus.OVERRUN, expOverrun);
            repeat ($urandom_range(0, 40)) @(negedge CLK);
            drain();
        end

        // Reset in the middle of bit 4 with a byte pending must wipe everything.
        b = 8'($urandom);
        sendFrame(b, 1'b1, -1, -1);
        modelRx(b);
        check("pendingBeforeReset", bus.IRQ, 1'b1);
        sendFrame(8'hC3, 1'b1, -1, 5 * CPB + 4);
        #2 RESET_N = 1'b0;
        #1 checkResetValues("midReset");
        expQ.delete();
        expOverrun = 1'b0;
        expData    = 8'h00;
        @(negedge CLK);
        #2 RESET_N = 1'b1;
        @(negedge CLK);
        rx = 1'b1;
        watch(200, irqHi, ferrHi);
        check("abortedByteDropped", 16'(irqHi), 16'd0);
        sendFrame(8'h7A, 1'b1, -1, -1);
        rx = 1'b1;
        modelRx(8'h7A);
        serviceOne(1'b0);
        check("afterResetByte", expData, 8'h7A);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
